// File: rtl/alu_share_arbiter_if.sv
// Request/response/ALU bundle for alu_share_arbiter.
// slave: arbiter view; master: requesters plus external ALU.
interface alu_share_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OP_W   = 3
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_control;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp0_ready, rsp1_ready, alu_result, alu_zero,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp_result, rsp_zero, alu_a, alu_b, alu_control
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp0_ready, rsp1_ready, alu_result, alu_zero,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp_result, rsp_zero, alu_a, alu_b, alu_control
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, one op in flight.
// Optional grant counters enabled with macro ALU_ARB_PERF_CNT_EN.
module alu_share_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned OP_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_share_arbiter_if.slave   bus
`ifdef ALU_ARB_PERF_CNT_EN
  ,
  input  logic                 cnt_clr,
  output logic [15:0]          grant_cnt0,
  output logic [15:0]          grant_cnt1
`endif
);
  typedef enum logic {IDLE, HOLD} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;

  logic owner_ready;
  logic can_accept;
  logic grant_vld;
  logic grant_id;

  always_comb begin
    owner_ready = owner_q ? bus.rsp1_ready : bus.rsp0_ready;
    // Consuming the held response frees the slot in the same cycle.
    can_accept  = !rst && ((state_q == IDLE) || owner_ready);
    grant_vld   = 1'b0;
    grant_id    = 1'b0;
    if (can_accept) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = ~last_grant_q;
      end else if (bus.req0_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b0;
      end else if (bus.req1_valid) begin
        grant_vld = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign bus.req0_ready = grant_vld & ~grant_id;
  assign bus.req1_ready = grant_vld & grant_id;

  always_comb begin
    bus.alu_a       = '0;
    bus.alu_b       = '0;
    bus.alu_control = '0;
    if (grant_vld) begin
      bus.alu_a       = grant_id ? bus.req1_a  : bus.req0_a;
      bus.alu_b       = grant_id ? bus.req1_b  : bus.req0_b;
      bus.alu_control = grant_id ? bus.req1_op : bus.req0_op;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    if (grant_vld) begin
      state_d      = HOLD;
      owner_d      = grant_id;
      last_grant_d = grant_id;
      rsp0_valid_d = ~grant_id;
      rsp1_valid_d = grant_id;
      rsp_result_d = bus.alu_result;
      rsp_zero_d   = bus.alu_zero;
    end else if ((state_q == HOLD) && owner_ready) begin
      state_d      = IDLE;
      rsp0_valid_d = 1'b0;
      rsp1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;

`ifdef ALU_ARB_PERF_CNT_EN
  logic [15:0] grant_cnt0_q, grant_cnt0_d;
  logic [15:0] grant_cnt1_q, grant_cnt1_d;

  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    if (cnt_clr) begin
      grant_cnt0_d = '0;
      grant_cnt1_d = '0;
    end else begin
      if (bus.req0_ready && (grant_cnt0_q != '1)) grant_cnt0_d = grant_cnt0_q + 16'd1;
      if (bus.req1_ready && (grant_cnt1_q != '1)) grant_cnt1_d = grant_cnt1_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed vector bench for alu_share_arbiter with a behavioural ALU.
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.DATA_W(16), .OP_W(3)) bus ();

`ifdef ALU_ARB_PERF_CNT_EN
  logic        cnt_clr;
  logic [15:0] grant_cnt0, grant_cnt1;
  alu_share_arbiter #(.DATA_W(16), .OP_W(3)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cnt_clr(cnt_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );
`else
  alu_share_arbiter #(.DATA_W(16), .OP_W(3)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  always_comb begin
    case (bus.alu_control)
      3'b001:  bus.alu_result = bus.alu_a - bus.alu_b;
      3'b010:  bus.alu_result = bus.alu_a & bus.alu_b;
      3'b011:  bus.alu_result = bus.alu_a | bus.alu_b;
      3'b100:  bus.alu_result = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 16'd1 : 16'd0;
      default: bus.alu_result = bus.alu_a + bus.alu_b;
    endcase
    bus.alu_zero = (bus.alu_result == 16'd0);
  end

  typedef struct packed {
    logic        v0;
    logic        v1;
    logic [15:0] a0;
    logic [15:0] b0;
    logic [2:0]  op0;
    logic [15:0] a1;
    logic [15:0] b1;
    logic [2:0]  op1;
    logic        rdy0;
    logic        rdy1;
    logic [2:0]  ctl;
    logic        rsp0;
    logic        rsp1;
    logic [15:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [15:0] a0, input logic [15:0] b0, input logic [2:0] op0,
                       input logic v1, input logic [15:0] a1, input logic [15:0] b1, input logic [2:0] op1);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
  endtask

  initial begin
    // last_grant resets to 1, so contention starts with requester 0
    vecs[0] = '{1'b1, 1'b1, 16'd9, 16'd9, 3'b001, 16'h00F0, 16'h000F, 3'b011, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 16'd9, 16'd9, 3'b001, 16'h00F0, 16'h000F, 3'b011, 1'b0, 1'b1, 3'b011, 1'b0, 1'b1, 16'h00FF, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 16'd9, 16'd9, 3'b001, 16'h00F0, 16'h000F, 3'b011, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 16'd9, 16'd9, 3'b001, 16'h00F0, 16'h000F, 3'b011, 1'b0, 1'b1, 3'b011, 1'b0, 1'b1, 16'h00FF, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'd5, 16'd7, 3'b000, 16'd0, 16'd0, 3'b000, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 16'h000C, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 16'd2, 16'd3, 3'b111, 16'd0, 16'd0, 3'b000, 1'b1, 1'b0, 3'b111, 1'b1, 1'b0, 16'h0005, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 16'd0, 16'd0, 3'b000, 16'hF0F0, 16'h0FF0, 3'b010, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 16'h00F0, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 16'd0, 16'd0, 3'b000, 16'd0, 16'd0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 16'h00F0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 16'd0, 16'd0, 3'b000, 16'd3, 16'd4, 3'b100, 1'b0, 1'b1, 3'b100, 1'b0, 1'b1, 16'h0001, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 16'd1, 16'd2, 3'b001, 16'd1, 16'd1, 3'b000, 1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 16'hFFFF, 1'b0};

    rst = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
`ifdef ALU_ARB_PERF_CNT_EN
    cnt_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    chk("reset_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    chk("reset_rsp_result", 32'(bus.rsp_result), 32'd0);
    chk("reset_rsp_zero",   32'(bus.rsp_zero),   32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].op0, vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].op1);
      #1;
      chk($sformatf("vec%0d_req0_ready", i), 32'(bus.req0_ready), 32'(vecs[i].rdy0));
      chk($sformatf("vec%0d_req1_ready", i), 32'(bus.req1_ready), 32'(vecs[i].rdy1));
      chk($sformatf("vec%0d_alu_control", i), 32'(bus.alu_control), 32'(vecs[i].ctl));
      chk($sformatf("vec%0d_alu_a", i), 32'(bus.alu_a),
          vecs[i].rdy0 ? 32'(vecs[i].a0) : (vecs[i].rdy1 ? 32'(vecs[i].a1) : 32'd0));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_rsp0_valid", i), 32'(bus.rsp0_valid), 32'(vecs[i].rsp0));
      chk($sformatf("vec%0d_rsp1_valid", i), 32'(bus.rsp1_valid), 32'(vecs[i].rsp1));
      chk($sformatf("vec%0d_rsp_result", i), 32'(bus.rsp_result), 32'(vecs[i].res));
      chk($sformatf("vec%0d_rsp_zero", i),   32'(bus.rsp_zero),   32'(vecs[i].zero));
    end

    // Back-pressure: requester 1 response held while requester 0 waits.
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b1, 16'd3, 16'd4, 3'b100);
    bus.rsp1_ready = 1'b0;
    #1 chk("bp_req1_ready", 32'(bus.req1_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
    @(negedge clk);
    drive(1'b1, 16'd10, 16'd3, 3'b001, 1'b0, '0, '0, '0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_hold%0d_req0_ready", c), 32'(bus.req0_ready), 32'd0);
      chk($sformatf("bp_hold%0d_rsp1_valid", c), 32'(bus.rsp1_valid), 32'd1);
      chk($sformatf("bp_hold%0d_result", c),     32'(bus.rsp_result), 32'd1);
      @(negedge clk);
    end
    bus.rsp1_ready = 1'b1;
    #1 chk("bp_release_req0_ready", 32'(bus.req0_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_after_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    chk("bp_after_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    chk("bp_after_result",     32'(bus.rsp_result), 32'd7);

    // Asynchronous reset while a response is held, then contention.
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    bus.rsp0_ready = 1'b0;
    #1 chk("rst_pre_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    chk("rst_async_result",     32'(bus.rsp_result), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.rsp0_ready = 1'b1;
    drive(1'b1, 16'd5, 16'd7, 3'b000, 1'b1, 16'd1, 16'd1, 3'b000);
    #1;
    chk("rst_contend_req0_ready", 32'(bus.req0_ready), 32'd1);
    chk("rst_contend_req1_ready", 32'(bus.req1_ready), 32'd0);
    @(posedge clk); #1;
    chk("rst_contend_result", 32'(bus.rsp_result), 32'd12);

`ifdef ALU_ARB_PERF_CNT_EN
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("cnt_clr0", 32'(grant_cnt0), 32'd0);
    chk("cnt_clr1", 32'(grant_cnt1), 32'd0);
    drive(1'b1, 16'd1, 16'd1, 3'b000, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b1, 16'd1, 16'd1, 3'b000);
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("cnt_grant0", 32'(grant_cnt0), 32'd3);
    chk("cnt_grant1", 32'(grant_cnt1), 32'd1);
    drive(1'b1, 16'd1, 16'd1, 3'b000, 1'b0, '0, '0, '0);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("cnt_clr_wins0", 32'(grant_cnt0), 32'd0);
    chk("cnt_clr_wins1", 32'(grant_cnt1), 32'd0);
    repeat (65535) @(negedge clk);
    chk("cnt_reach_max", 32'(grant_cnt0), 32'hFFFF);
    @(negedge clk);
    chk("cnt_saturate", 32'(grant_cnt0), 32'hFFFF);
    drive(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single 16-bit combinational ALU between two requesters: requester 0 is the main execute path, requester 1 is the address/branch-compare unit. The block arbitrates round-robin, drives the ALU operands and opcode for the granted request, and registers the ALU result and zero flag. It returns the registered response to the owning requester over a valid/ready handshake. At most one operation is in flight.

Parameters:
DATA_W, 16, operand/result width (matches the ALU)
OP_W, 3, ALU control width (000 add, 001 sub, 010 and, 011 or, 100 slt)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  DATA_W  requester 0 operand a
req0_b  input  DATA_W  requester 0 operand b
req0_op  input  OP_W  requester 0 ALU control
req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0, for requester 1
rsp0_valid  output  1  response for requester 0 held
rsp0_ready  input  1  requester 0 consumes response
rsp1_valid  output  1  response for requester 1 held
rsp1_ready  input  1  requester 1 consumes response
rsp_result  output  DATA_W  registered ALU result (shared by both responses)
rsp_zero  output  1  registered ALU zero flag
alu_a  output  DATA_W  to ALU operand a
alu_b  output  DATA_W  to ALU operand b
alu_control  output  OP_W  to ALU control
alu_result  input  DATA_W  from ALU result
alu_zero  input  1  from ALU zero flag

Behaviour:
- Reset (async, rst=1): state=IDLE, rsp0_valid=0, rsp1_valid=0, rsp_result=0, rsp_zero=0, last_grant=1 (requester 0 wins the first contention). All outputs are held at these values while rst=1.
- States: IDLE (no response held) and HOLD (response held for owner).
- Accept condition: can_accept = (state==IDLE) | (state==HOLD & owner's rsp_ready). A response consumed in a cycle frees the slot in that same cycle, so throughput is 1 op/cycle when rsp_ready is held high.
- Grant (combinational, only when can_accept):
  - Only req0_valid: grant 0.
  - Only req1_valid: grant 1.
  - Both valid: grant the requester not equal to last_grant.
  - Neither valid: no grant.
- reqN_ready = can_accept & grant==N. The ready signals are never both high.
- ALU drive: while a grant is active, alu_a/alu_b/alu_control = the granted requester's operands and op. With no grant, drive 0/0/000.
- On the edge of a granted cycle:
  - rsp_result<=alu_result, rsp_zero<=alu_zero.
  - owner<=grant, last_grant<=grant, state<=HOLD.
  - rsp_owner_valid=1, the other rsp_valid=0.
- Latency: request accepted in cycle N; response is valid from cycle N+1 and held stable until consumed.
- In HOLD with owner rsp_ready=1 and no new grant: state<=IDLE, rsp valids cleared.
- In HOLD with owner rsp_ready=0: no acceptance, all reqN_ready=0, response stable. Back-pressure stalls both requesters.
- A non-owner rsp_ready is ignored.
- Opcodes are passed through unchanged. Codes 101..111 are forwarded and the ALU defines the result (add).
- Reset mid-operation: a held response is discarded and not replayed.
- Requester rules: a requester must hold its valid/a/b/op stable until ready. The block does not check this.

Optional Feature:
Macro ALU_ARB_PERF_CNT_EN.
- Defined: adds outputs grant_cnt0 and grant_cnt1 (16 bits each) and input cnt_clr (1 bit).
  - Each counter increments on its requester's accepted request and saturates at 16'hFFFF.
  - cnt_clr=1 synchronously zeroes both counters. A clear in the same cycle as a grant wins.
  - rst zeroes both counters.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then req0 add a=5,b=7 with rsp0_ready=1 -> req0_ready in cycle 0, rsp0_valid in cycle 1, rsp_result=12, rsp_zero=0, alu_control=000 during the grant.
- Both requesters valid continuously (req0 sub 9-9, req1 or 0x00F0|0x000F), both rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0. Results alternate 0 (zero=1) and 0x00FF (zero=0), one response per cycle.
- req1 slt a=3,b=4 with rsp1_ready=0 for 3 cycles while req0 is valid -> rsp1_valid and result=1 held 3 cycles, req0_ready=0 throughout. The cycle rsp1_ready rises, req0_ready=1.
- Assert rst while in HOLD with rsp0_valid=1 -> rsp0_valid=0 and rsp_result=0 immediately (asynchronous). After release, the next contended grant goes to requester 0.
- Opcode 111 with a=2,b=3 -> rsp_result=5, forwarded unchanged on alu_control.
- With ALU_ARB_PERF_CNT_EN: 3 grants to req0 and 1 to req1 -> grant_cnt0=3, grant_cnt1=1. cnt_clr in a grant cycle -> both 0. Preload 16'hFFFF, then grant -> stays 16'hFFFF.
